// File: rtl/regfile_access_ctrl.sv
// Operand-fetch / writeback sequencer between decode and the 8x8 register file + ALU.
// Optional R0_HARDWIRED_EN: r0 reads as zero and writes to r0 are dropped (still retired).
module regfile_access_ctrl #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int OPC_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [OPC_W-1:0]  instr_op,
   input  logic [ADDR_W-1:0] instr_rd,
   input  logic [ADDR_W-1:0] instr_rs1,
   input  logic [ADDR_W-1:0] instr_rs2,
   input  logic [DATA_W-1:0] instr_imm,
   input  logic              instr_is_imm,
   input  logic              instr_no_wb,
   output logic [ADDR_W-1:0] rf_rd_addr1,
   output logic [ADDR_W-1:0] rf_rd_addr2,
   input  logic [DATA_W-1:0] rf_rd_data1,
   input  logic [DATA_W-1:0] rf_rd_data2,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data_imm,
   output logic              rf_wr_sel,
   output logic              alu_start,
   output logic [OPC_W-1:0]  alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic              alu_done,
   output logic [7:0]        retire_cnt,
   output logic              err_timeout
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

   state_t             state_q, state_d;
   logic [OPC_W-1:0]   op_q, op_d;
   logic [ADDR_W-1:0]  rd_q, rd_d;
   logic [ADDR_W-1:0]  addr1_q, addr1_d;
   logic [ADDR_W-1:0]  addr2_q, addr2_d;
   logic [DATA_W-1:0]  imm_q, imm_d;
   logic               is_imm_q, is_imm_d;
   logic               no_wb_q, no_wb_d;
   logic [DATA_W-1:0]  a_q, a_d;
   logic [DATA_W-1:0]  b_q, b_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         retire_q, retire_d;
   logic               err_q, err_d;
   logic               wr_allow;

`ifdef R0_HARDWIRED_EN
   assign wr_allow = (rd_q != '0);
`else
   assign wr_allow = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      addr1_d     = addr1_q;
      addr2_d     = addr2_q;
      imm_d       = imm_q;
      is_imm_d    = is_imm_q;
      no_wb_d     = no_wb_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      retire_d    = retire_q;
      err_d       = err_q;
      instr_ready = 1'b0;
      alu_start   = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               op_d     = instr_op;
               rd_d     = instr_rd;
               imm_d    = instr_imm;
               is_imm_d = instr_is_imm;
               no_wb_d  = instr_no_wb;
               // Read addresses only move for instructions that fetch, so they hold otherwise.
               if (!instr_is_imm) begin
                  addr1_d = instr_rs1;
                  addr2_d = instr_rs2;
               end
               state_d = instr_is_imm ? WB : FETCH;
            end
         end
         FETCH: begin
            a_d   = rf_rd_data1;
            b_d   = rf_rd_data2;
`ifdef R0_HARDWIRED_EN
            if (addr1_q == '0) a_d = '0;
            if (addr2_q == '0) b_d = '0;
`endif
            cnt_d   = '0;
            state_d = EXEC;
         end
         EXEC: begin
            alu_start = (cnt_q == '0);
            // A done level still held from the previous op is ignored in the launch cycle.
            if ((cnt_q != '0) && alu_done) begin
               if (no_wb_q) begin
                  state_d  = IDLE;
                  retire_d = retire_q + 8'd1;
               end else begin
                  state_d = WB;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WB: begin
            state_d  = IDLE;
            retire_d = retire_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         imm_q    <= '0;
         is_imm_q <= 1'b0;
         no_wb_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         retire_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         addr1_q  <= addr1_d;
         addr2_q  <= addr2_d;
         imm_q    <= imm_d;
         is_imm_q <= is_imm_d;
         no_wb_q  <= no_wb_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         retire_q <= retire_d;
         err_q    <= err_d;
      end
   end

   // Reset asserted during WB must suppress the write at that same edge.
   assign rf_we          = (state_q == WB) & ~rst & wr_allow;
   assign rf_wr_addr     = rd_q;
   assign rf_wr_sel      = is_imm_q;
   assign rf_wr_data_imm = imm_q;
   assign rf_rd_addr1    = addr1_q;
   assign rf_rd_addr2    = addr2_q;
   assign alu_op         = op_q;
   assign alu_a          = a_q;
   assign alu_b          = b_q;
   assign retire_cnt     = retire_q;
   assign err_timeout    = err_q;

endmodule
